// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and constants for the result transmit arbiter
package freq_meter_pkg;

  // Default requester count and the fixed requester slots
  localparam int NREQ_DEFAULT = 3;
  localparam int REQ_FREQ     = 0;
  localparam int REQ_PERIOD   = 1;
  localparam int REQ_STATUS   = 2;

  // Arbiter states
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT_TX = 2'd2,
    S_DRAIN   = 2'd3
  } arb_state_e;

  // Next requester index with wrap back to zero
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/result_tx_arbiter_if.sv
// rtl/result_tx_arbiter_if.sv - requester and transmitter bundle of the result arbiter
interface result_tx_arbiter_if
  import freq_meter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int DW   = 8
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data;
  logic [NREQ-1:0]    last;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    grant;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;

  // Arbiter side
  modport master (
    input  req, data, last, tx_busy,
    output ack, grant, tx_start, tx_data
  );

  // Requesters and transmitter side
  modport slave (
    output req, data, last, tx_busy,
    input  ack, grant, tx_start, tx_data
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin one-hot pick starting at a pointer
module rr_pick
  import freq_meter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] pick_o
);

  logic found;
  int   idx;

  // First set request at or above ptr_i, wrapping past the top requester
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = (int'(ptr_i) < NREQ) ? int'(ptr_i) : 0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && req_i[j]) begin
          pick_o[j] = 1'b1;
          found     = 1'b1;
        end
      end
      idx = wrap_inc(idx, NREQ);
    end
  end

endmodule

// File: rtl/result_tx_arbiter.sv
// rtl/result_tx_arbiter.sv - round-robin arbiter feeding result frames to a byte transmitter
module result_tx_arbiter
  import freq_meter_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk_i,
  input  logic                rst_i,
  result_tx_arbiter_if.master bus,
  output logic                idle_o,
  output logic                err_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  arb_state_e      state_q;
  logic [NREQ-1:0] grant_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   rr_ptr_q;
  logic [PW-1:0]   rr_ptr_d;
  logic [CW-1:0]   to_cnt_q;
  logic [CW-1:0]   to_cnt_d;
  logic            tx_start_q;
  logic [DW-1:0]   tx_data_q;
  logic            last_q;
  logic            err_q;
  logic [NREQ-1:0] sel_oh;
  logic [DW-1:0]   sel_data;
  logic            sel_last;
  logic            owner_req;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req_i  (bus.req),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick)
  );

  // Byte and last flag of the candidate in IDLE, of the owner otherwise
  always_comb begin
    sel_oh   = (state_q == S_IDLE) ? pick : grant_q;
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_oh[i]) begin
        sel_data = bus.data[i*DW +: DW];
        sel_last = bus.last[i];
      end
    end
  end

  // Owner still requesting; pointer that gives the owner lowest priority next
  always_comb begin
    owner_req = |(bus.req & grant_q);
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        rr_ptr_d = PW'(wrap_inc(i, NREQ));
      end
    end
  end

  // Saturating increment of the START wait counter
  always_comb begin
    to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;
  end

  // Arbitration FSM with registered grant, ack, tx and error outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      rr_ptr_q   <= '0;
      to_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!bus.tx_busy && (|bus.req)) begin
            grant_q    <= pick;
            tx_data_q  <= sel_data;
            last_q     <= sel_last;
            tx_start_q <= 1'b1;
            to_cnt_q   <= '0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bus.tx_busy) begin
            ack_q      <= grant_q;
            tx_start_q <= 1'b0;
            state_q    <= S_WAIT_TX;
          end else if (to_cnt_d == TO_MAX) begin
            to_cnt_q   <= to_cnt_d;
            err_q      <= 1'b1;
            tx_start_q <= 1'b0;
            state_q    <= S_DRAIN;
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end
        S_WAIT_TX: begin
          if (!bus.tx_busy) begin
            if (last_q || !owner_req) begin
              // Frame finished, or the owner withdrew before its next byte
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
              state_q  <= S_IDLE;
            end else begin
              tx_data_q  <= sel_data;
              last_q     <= sel_last;
              tx_start_q <= 1'b1;
              to_cnt_q   <= '0;
              state_q    <= S_START;
            end
          end
        end
        S_DRAIN: begin
          if (!owner_req) begin
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign idle_o       = (state_q == S_IDLE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_result_tx_arbiter.sv
// tb/tb_result_tx_arbiter.sv - scoreboard bench for the result transmit arbiter
`timescale 1ns/1ps
module tb_result_tx_arbiter;
  import freq_meter_pkg::*;

  localparam int NREQ    = 3;
  localparam int DW      = 8;
  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;
  logic err;

  result_tx_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  result_tx_arbiter #(
    .NREQ    (NREQ),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus    (bus),
    .idle_o (idle),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [8:0]  fq[NREQ][$];   // bytes still to be offered by each requester {last, byte}
  logic [8:0]  mq[NREQ][$];   // model copy of frames awaiting planning
  logic [10:0] exp_q[$];      // expected accepted bytes {grant, byte}
  int          m_ptr = 0;
  int          tx_mode = 0;   // 0 normal, 1 forced busy, 2 never responds
  bit          rand_busy = 1'b0;
  int          busy_cnt = 0;
  bit          abort_after[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_frame(input int r, input int len, input bit to_model);
    logic [7:0] b;
    logic [8:0] ent;
    for (int j = 0; j < len; j++) begin
      b   = 8'($urandom);
      ent = {(j == len - 1), b};
      fq[r].push_back(ent);
      if (to_model) mq[r].push_back(ent);
    end
  endtask

  // Reference: whole frames granted in round-robin order from the model pointer
  task automatic plan();
    int g;
    int c;
    logic [8:0] e;
    while (mq[0].size() + mq[1].size() + mq[2].size() > 0) begin
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      do begin
        e = mq[g].pop_front();
        exp_q.push_back({NREQ'(1 << g), e[7:0]});
      end while (!e[8] && mq[g].size() > 0);
      m_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic wait_done(input string name, input int bound);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < bound) begin
      tick(1);
      n++;
      if (exp_q.size() == 0 && idle && bus.req == '0 && !bus.tx_busy) ok = 1'b1;
    end
    check(name, 32'(ok), 1);
  endtask

  // Requesters and transmitter, updated just after each rising edge
  initial begin : drv
    logic [NREQ-1:0]    req_v;
    logic [NREQ-1:0]    last_v;
    logic [NREQ*DW-1:0] data_v;
    logic [8:0]         ent;
    bus.req     = '0;
    bus.data    = '0;
    bus.last    = '0;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i] && fq[i].size() > 0) begin
          ent = fq[i].pop_front();
          if (abort_after[i]) begin
            fq[i].delete();
            abort_after[i] = 1'b0;
          end
        end
      end
      req_v  = '0;
      last_v = '0;
      data_v = '0;
      for (int i = 0; i < NREQ; i++) begin
        if (fq[i].size() > 0) begin
          ent                 = fq[i][0];
          req_v[i]            = 1'b1;
          last_v[i]           = ent[8];
          data_v[i*DW +: DW]  = ent[7:0];
        end
      end
      bus.req  = req_v;
      bus.last = last_v;
      bus.data = data_v;
      if (tx_mode == 1) begin
        bus.tx_busy = 1'b1;
      end else if (tx_mode == 2) begin
        bus.tx_busy = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        bus.tx_busy = (busy_cnt > 0);
      end else if (bus.tx_start) begin
        busy_cnt    = rand_busy ? int'($urandom_range(1, 5)) : 4;
        bus.tx_busy = 1'b1;
      end else begin
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on every ack
  initial begin : mon
    logic [10:0] e;
    forever begin
      @(negedge clk);
      check("grant_onehot0", 32'($onehot0(bus.grant)), 1);
      check("ack_in_grant", 32'(bus.ack & ~bus.grant), 0);
      check("start_ack_excl", 32'(bus.tx_start & (|bus.ack)), 0);
      if (|bus.ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(bus.ack), 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", 32'(bus.ack), 32'(e[10:8]));
          check("tx_byte", 32'(bus.tx_data), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin : stim
    int n_bad;
    int n_ack;
    int n_hi;
    int n_st;
    bit got;
    bit prev;
    logic [2:0] mask;
    logic [8:0] ent;

    rst = 1'b1;
    tick(3);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_tx_start", 32'(bus.tx_start), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_err", 32'(err), 0);
    check("rst_idle", 32'(idle), 1);
    rst = 1'b0;
    m_ptr = 0;
    tick(1);

    // All three requesting one-byte frames, requester 0 twice
    add_frame(REQ_FREQ, 1, 1);
    add_frame(REQ_FREQ, 1, 1);
    add_frame(REQ_PERIOD, 1, 1);
    add_frame(REQ_STATUS, 1, 1);
    plan();
    wait_done("rr_rotation_done", 400);

    // Three-byte frame on requester 1
    fq[REQ_PERIOD].push_back({1'b0, 8'h12}); mq[REQ_PERIOD].push_back({1'b0, 8'h12});
    fq[REQ_PERIOD].push_back({1'b0, 8'h34}); mq[REQ_PERIOD].push_back({1'b0, 8'h34});
    fq[REQ_PERIOD].push_back({1'b1, 8'h56}); mq[REQ_PERIOD].push_back({1'b1, 8'h56});
    plan();
    n_bad = 0;
    n_ack = 0;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      tick(1);
      if (bus.grant != '0 && bus.grant != 3'b010) n_bad++;
      if (bus.ack[REQ_PERIOD]) n_ack++;
      if (exp_q.size() == 0 && idle && bus.req == '0 && !bus.tx_busy) got = 1'b1;
    end
    check("frame3_done", 32'(got), 1);
    check("frame3_grant_stray", 32'(n_bad), 0);
    check("frame3_acks", 32'(n_ack), 3);
    check("frame3_idle", 32'(idle), 1);

    // Transmitter busy while a request is pending
    tx_mode = 1;
    tick(2);
    add_frame(REQ_FREQ, 1, 1);
    plan();
    n_bad = 0;
    repeat (6) begin
      tick(1);
      if (bus.grant != '0) n_bad++;
    end
    check("stall_no_grant", 32'(n_bad), 0);
    tx_mode = 0;
    tick(1);
    check("stall_release_grant0", 32'(bus.grant), 0);
    tick(1);
    check("stall_grant", 32'(bus.grant), 32'(3'b001));
    wait_done("stall_done", 200);

    // Transmitter never answers
    tx_mode = 2;
    tick(1);
    add_frame(REQ_STATUS, 1, 0);
    n_hi = 0;
    got  = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      tick(1);
      if (err) got = 1'b1;
      else if (bus.tx_start) n_hi++;
    end
    check("to_err_seen", 32'(got), 1);
    check("to_start_cycles", 32'(n_hi), TIMEOUT);
    check("to_start_low", 32'(bus.tx_start), 0);
    check("to_grant_at_err", 32'(bus.grant), 32'(3'b100));
    tick(1);
    check("to_err_pulse", 32'(err), 0);
    tick(3);
    check("to_grant_held", 32'(bus.grant), 32'(3'b100));
    check("to_not_idle", 32'(idle), 0);
    fq[REQ_STATUS].delete();
    tx_mode = 0;
    tick(2);
    check("drain_grant", 32'(bus.grant), 0);
    check("drain_idle", 32'(idle), 1);
    m_ptr = 0;

    // Requester 0 withdraws after the first byte of a two-byte frame
    add_frame(REQ_FREQ, 2, 0);
    abort_after[REQ_FREQ] = 1'b1;
    ent = fq[REQ_FREQ][0];
    exp_q.push_back({3'b001, ent[7:0]});
    n_st = 0;
    prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (bus.tx_start && !prev) n_st++;
      prev = bus.tx_start;
    end
    check("abort_starts", 32'(n_st), 1);
    check("abort_idle", 32'(idle), 1);
    m_ptr = 1;
    add_frame(REQ_FREQ, 1, 1);
    add_frame(REQ_STATUS, 1, 1);
    plan();
    wait_done("after_abort_done", 300);

    // Reset while waiting on the transmitter
    add_frame(REQ_PERIOD, 3, 0);
    ent = fq[REQ_PERIOD][0];
    exp_q.push_back({3'b010, ent[7:0]});
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick(1);
      if (bus.ack[REQ_PERIOD]) got = 1'b1;
    end
    check("wt_ack_seen", 32'(got), 1);
    rst = 1'b1;
    fq[REQ_PERIOD].delete();
    tick(1);
    check("wt_rst_grant", 32'(bus.grant), 0);
    check("wt_rst_tx_start", 32'(bus.tx_start), 0);
    check("wt_rst_idle", 32'(idle), 1);
    rst = 1'b0;
    m_ptr = 0;
    tick(1);
    add_frame(REQ_STATUS, 1, 1);
    plan();
    wait_done("post_reset_done", 300);

    // Random rounds of simultaneous multi-frame requests
    rand_busy = 1'b1;
    for (int r = 0; r < 20; r++) begin
      mask = 3'($urandom_range(1, 7));
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          repeat ($urandom_range(1, 2)) add_frame(i, $urandom_range(1, 4), 1);
        end
      end
      plan();
      wait_done("rand_round_done", 800);
      tick($urandom_range(0, 3));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/result_tx_arbiter.md
RESULT_TX_ARBITER -- requirements
Module: result_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of requesters; 0 = frequency result, 1 = period result, 2 = status.
REQ-002 Parameter DW, default 8: byte width of the transmit data path.
REQ-003 Parameter TIMEOUT, default 1023: maximum cycles tx_start may wait for tx_busy to rise.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  NREQ  per-requester frame request; held high for the whole frame.
REQ-007 data  in  NREQ*DW  per-requester current byte; requester i occupies bits [i*DW +: DW].
REQ-008 last  in  NREQ  per-requester flag: current byte is the final byte of the frame.
REQ-009 ack  out  NREQ  one-cycle pulse: current byte of the granted requester was accepted.
REQ-010 grant  out  NREQ  one-hot owner of the transmitter; all zero when no requester owns it.
REQ-011 tx_start  out  1  byte transmit request to the transmitter.
REQ-012 tx_data  out  DW  byte presented to the transmitter.
REQ-013 tx_busy  in  1  transmitter busy flag.
REQ-014 idle  out  1  high exactly when the state is IDLE.
REQ-015 err  out  1  one-cycle pulse on a transmitter timeout.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT_TX and DRAIN.
REQ-017 IDLE: when tx_busy=0 and req!=0, the arbiter SHALL select the first set req bit searching upward from rr_ptr with wrap, register grant and go to START; grant is visible one cycle after req is sampled.
REQ-018 START: tx_data SHALL be registered from data[g], last SHALL be captured and tx_start SHALL be 1; when tx_busy=1, ack[g] SHALL pulse for one cycle, tx_start SHALL go to 0 and the state SHALL go to WAIT_TX.
REQ-019 WAIT_TX: when tx_busy=0, the state SHALL go to IDLE if the captured last=1, otherwise to START for the next byte of the same grant.
REQ-020 If req[g]=0 on entry to START, the frame SHALL abort: grant clears and the state goes to IDLE without tx_start.
REQ-021 On frame end or abort, rr_ptr SHALL be set to (g+1) mod NREQ, so a requester that just finished has lowest priority.
REQ-022 A timeout counter SHALL count cycles in START; when it reaches TIMEOUT with tx_busy still 0, err SHALL pulse, tx_start SHALL drop and the state SHALL go to DRAIN.
REQ-023 DRAIN: grant SHALL stay held until req[g]=0, then grant clears, rr_ptr advances and the state goes to IDLE.
REQ-024 The timeout counter SHALL clear on every entry to START and SHALL saturate, never wrap.
REQ-025 If tx_busy=1 in IDLE, arbitration SHALL stall until it is 0.
REQ-026 A change in req for a non-granted requester SHALL never preempt a frame in progress.
REQ-027 grant SHALL always be one-hot or zero; ack SHALL be a subset of grant; tx_start and ack SHALL never be high in the same cycle.

Reset
REQ-028 On rst=1, state SHALL be IDLE, grant=0, ack=0, tx_start=0, tx_data=0, err=0, rr_ptr=0, the timeout counter=0 and idle=1, effective at the next clock edge.
REQ-029 rst asserted mid-frame SHALL drop tx_start and grant at the next edge; the partial frame SHALL not be resumed.

Structure
REQ-030 The state enum, NREQ default and requester index constants SHALL reside in shared package freq_meter_pkg.
REQ-031 The round-robin selection SHALL be sub-module rr_pick (combinational: req, rr_ptr -> one-hot pick).

Verification
REQ-032 req=3'b111 from reset, one-byte frames, tx_busy for 4 cycles per byte -> grant sequence 001, 010, 100, 001.
REQ-033 req[1] frame 0x12,0x34,0x56 with last on 0x56 -> tx_data 0x12,0x34,0x56 in order; 3 ack pulses; grant=010 throughout; then IDLE.
REQ-034 tx_busy held 0 in START -> err pulses after 1023 cycles; tx_start=0; grant held until req[g] drops.
REQ-035 req[0] drops after its first byte of a 2-byte frame -> no second tx_start; IDLE; rr_ptr=1.
REQ-036 rst=1 during WAIT_TX -> next cycle grant=0, tx_start=0, idle=1; req[2] alone is then granted.
REQ-037 tx_busy=1 while entering IDLE with req=001 -> no grant until tx_busy=0, then grant=001 one cycle later.
